// File: rtl/mips_pkg.sv
// Shared defaults, state encoding and entry layout for the MIPS instruction-fetch front end.
package mips_pkg;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

   // Low address bits cleared to force word alignment of fetch addresses.
   localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      STALL   = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [DEFAULT_DATA_WIDTH-1:0] instr;
      logic [DEFAULT_ADDR_WIDTH-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_fifo.sv
// Prefetch FIFO: power-of-two circular buffer with push/pop/flush and occupancy count.
// Flush has priority over push and pop; the storage array itself is not reset.
module mips_fetch_fifo
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int unsigned WIDTH = $bits(fetch_entry_t),
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] head_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i && (count_q != CNT_W'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
         else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch front end: req/ack imem port, prefetch FIFO, redirect with flush.
// Optional MIPS_FETCH_BYPASS_EN forwards an acked instruction to decode when the FIFO is empty.
//   state   | meaning
//   FETCH   | request at fetch_pc outstanding on the imem port
//   STALL   | FIFO full, no request until decode pops
//   DISCARD | stale request still in flight; its response is dropped
module mips_fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned           FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [ADDR_WIDTH-1:0] out_pc_plus4
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] instr;
      logic [ADDR_WIDTH-1:0] pc;
   } entry_t;

   fetch_state_t          state_q;
   logic [ADDR_WIDTH-1:0] fetch_pc_q;
   logic [ADDR_WIDTH-1:0] disc_addr_q;
   logic [ADDR_WIDTH-1:0] redirect_tgt;

   logic                  req_act;
   logic                  fetch_ack;
   logic                  bypass;
   logic                  push;
   logic                  pop;
   logic                  fill_last;
   logic                  fifo_valid;
   logic [CNT_W-1:0]      fifo_count;
   entry_t                push_entry;
   entry_t                head_entry;
   entry_t                out_entry;

   assign req_act      = !rst && (state_q != STALL);
   assign imem_req     = req_act;
   assign imem_addr    = (state_q == DISCARD) ? disc_addr_q : fetch_pc_q;
   assign redirect_tgt = redirect_pc & ~ADDR_WIDTH'(INSTR_ALIGN_MASK);

   // Only a FETCH-state response without a competing redirect is ever kept.
   assign fetch_ack = req_act && imem_ack && (state_q == FETCH) && !redirect_valid;

`ifdef MIPS_FETCH_BYPASS_EN
   assign bypass = fetch_ack && (fifo_count == '0) && out_ready;
`else
   assign bypass = 1'b0;
`endif

   assign push       = fetch_ack && !bypass;
   assign pop        = !rst && fifo_valid && out_ready;
   assign fill_last  = push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH - 1));

   assign push_entry = '{instr: imem_rdata, pc: fetch_pc_q};

   mips_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect_valid),
      .head_o      (head_entry),
      .valid_o     (fifo_valid),
      .count_o     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FETCH;
         fetch_pc_q  <= RESET_PC;
         disc_addr_q <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc_q <= redirect_tgt;
         case (state_q)
            FETCH: begin
               // An unacked request cannot be withdrawn; remember its address.
               if (!imem_ack) begin
                  disc_addr_q <= fetch_pc_q;
                  state_q     <= DISCARD;
               end
            end
            STALL:   state_q <= FETCH;
            DISCARD: state_q <= DISCARD;
            default: state_q <= FETCH;
         endcase
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ack) begin
                  fetch_pc_q <= fetch_pc_q + PC_STEP;
                  if (fill_last) state_q <= STALL;
               end
            end
            STALL: begin
               if (pop) state_q <= FETCH;
            end
            DISCARD: begin
               if (imem_ack) state_q <= FETCH;
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   assign out_valid    = !rst && (fifo_valid || bypass);
   assign out_entry    = bypass ? push_entry : head_entry;
   assign out_instr    = out_valid ? out_entry.instr : '0;
   assign out_pc       = out_valid ? out_entry.pc : '0;
   assign out_pc_plus4 = out_valid ? (out_entry.pc + PC_STEP) : '0;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: two instances (RESET_PC 0x400 and 0xFFFFFFF8).
// Memory model returns addr ^ 0xC0000000 after mem_lat wait cycles.
module tb_mips_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

`ifdef MIPS_FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        a_rst, a_req, a_ack, a_redir_v, a_ready, a_ov;
   logic [31:0] a_addr, a_rdata, a_redir_pc, a_instr, a_pc, a_pc4;
   int          mem_lat;
   int          wait_cnt;

   assign a_ack   = a_req && (wait_cnt >= mem_lat);
   assign a_rdata = a_addr ^ 32'hC000_0000;

   always @(posedge clk) begin
      if (a_rst || !a_req || a_ack) wait_cnt <= 0;
      else                          wait_cnt <= wait_cnt + 1;
   end

   logic        b_rst, b_req, b_ack, b_redir_v, b_ready, b_ov;
   logic [31:0] b_addr, b_rdata, b_redir_pc, b_instr, b_pc, b_pc4;

   assign b_ack   = b_req;
   assign b_rdata = b_addr ^ 32'hC000_0000;

   mips_fetch_unit #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .FIFO_DEPTH (4),
      .RESET_PC   (32'h0000_0400)
   ) dut_a (
      .clk            (clk),
      .rst            (a_rst),
      .imem_req       (a_req),
      .imem_addr      (a_addr),
      .imem_ack       (a_ack),
      .imem_rdata     (a_rdata),
      .redirect_valid (a_redir_v),
      .redirect_pc    (a_redir_pc),
      .out_valid      (a_ov),
      .out_ready      (a_ready),
      .out_instr      (a_instr),
      .out_pc         (a_pc),
      .out_pc_plus4   (a_pc4)
   );

   mips_fetch_unit #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .FIFO_DEPTH (4),
      .RESET_PC   (32'hFFFF_FFF8)
   ) dut_b (
      .clk            (clk),
      .rst            (b_rst),
      .imem_req       (b_req),
      .imem_addr      (b_addr),
      .imem_ack       (b_ack),
      .imem_rdata     (b_rdata),
      .redirect_valid (b_redir_v),
      .redirect_pc    (b_redir_pc),
      .out_valid      (b_ov),
      .out_ready      (b_ready),
      .out_instr      (b_instr),
      .out_pc         (b_pc),
      .out_pc_plus4   (b_pc4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      a_rst = 1'b1; a_ready = 1'b1; a_redir_v = 1'b0; a_redir_pc = '0; mem_lat = 0;
      b_rst = 1'b1; b_ready = 1'b0; b_redir_v = 1'b0; b_redir_pc = '0;

      // Test 1: reset then zero-wait streaming from 0x400
      @(negedge clk); #1;
      chk("rst_req", a_req, 0);
      chk("rst_ov", a_ov, 0);
      chk("rst_instr", a_instr, 0);
      chk("rst_pc", a_pc, 0);
      chk("rst_pc4", a_pc4, 0);
      chk("b_rst_req", b_req, 0);
      @(negedge clk); a_rst = 1'b0; #1;
      chk("t1_c0_req", a_req, 1);
      chk("t1_c0_addr", a_addr, 32'h400);
      chk("t1_c0_ov", a_ov, BYP);
      chk("t1_c0_pc", a_pc, BYP ? 32'h400 : 32'h0);
      @(negedge clk); #1;
      chk("t1_c1_addr", a_addr, 32'h404);
      chk("t1_c1_ov", a_ov, 1);
      chk("t1_c1_pc", a_pc, BYP ? 32'h404 : 32'h400);
      chk("t1_c1_pc4", a_pc4, BYP ? 32'h408 : 32'h404);
      chk("t1_c1_instr", a_instr, BYP ? 32'hC000_0404 : 32'hC000_0400);
      @(negedge clk); #1;
      chk("t1_c2_addr", a_addr, 32'h408);
      chk("t1_c2_pc", a_pc, BYP ? 32'h408 : 32'h404);

      // Test 2: out_ready low fills the FIFO, then one pop restarts fetch
      @(negedge clk); a_rst = 1'b1; a_ready = 1'b0; #1;
      chk("t2_rst_req", a_req, 0);
      @(negedge clk); a_rst = 1'b0; #1;
      chk("t2_d0_addr", a_addr, 32'h400);
      chk("t2_d0_ack", a_ack, 1);
      @(negedge clk); #1;
      chk("t2_d1_addr", a_addr, 32'h404);
      @(negedge clk); #1;
      chk("t2_d2_addr", a_addr, 32'h408);
      @(negedge clk); #1;
      chk("t2_d3_addr", a_addr, 32'h40C);
      chk("t2_d3_req", a_req, 1);
      @(negedge clk); #1;
      chk("t2_d4_req", a_req, 0);
      chk("t2_d4_pc", a_pc, 32'h400);
      @(negedge clk); #1;
      chk("t2_d5_req", a_req, 0);
      @(negedge clk); a_ready = 1'b1; #1;
      chk("t2_d6_req", a_req, 0);
      chk("t2_d6_ov", a_ov, 1);
      @(negedge clk); a_ready = 1'b0; #1;
      chk("t2_d7_req", a_req, 1);
      chk("t2_d7_addr", a_addr, 32'h410);
      chk("t2_d7_pc", a_pc, 32'h404);
      @(negedge clk); #1;
      chk("t2_d8_req", a_req, 0);

      // Test 3: 3-wait memory, redirect to 0x1002 in wait cycle 1
      @(negedge clk); a_rst = 1'b1; a_ready = 1'b1; mem_lat = 3; #1;
      @(negedge clk); a_rst = 1'b0; #1;
      chk("t3_e0_addr", a_addr, 32'h400);
      chk("t3_e0_ack", a_ack, 0);
      @(negedge clk); a_redir_v = 1'b1; a_redir_pc = 32'h1002; #1;
      chk("t3_e1_addr", a_addr, 32'h400);
      chk("t3_e1_ov", a_ov, 0);
      @(negedge clk); a_redir_v = 1'b0; #1;
      chk("t3_e2_req", a_req, 1);
      chk("t3_e2_addr", a_addr, 32'h400);
      @(negedge clk); #1;
      chk("t3_e3_addr", a_addr, 32'h400);
      chk("t3_e3_ack", a_ack, 1);
      chk("t3_e3_ov", a_ov, 0);
      @(negedge clk); #1;
      chk("t3_e4_req", a_req, 1);
      chk("t3_e4_addr", a_addr, 32'h1000);
      chk("t3_e4_ov", a_ov, 0);
      for (int i = 0; i < 12; i++) begin
         if (a_ov) break;
         @(negedge clk); #1;
      end
      chk("t3_first_ov", a_ov, 1);
      chk("t3_first_pc", a_pc, 32'h1000);
      chk("t3_first_instr", a_instr, 32'hC000_1000);

      // Test 4: redirect with same-cycle ack, then redirect flushing a non-empty FIFO
      @(negedge clk); a_rst = 1'b1; a_ready = 1'b0; mem_lat = 0; #1;
      @(negedge clk); a_rst = 1'b0; a_redir_v = 1'b1; a_redir_pc = 32'h2000; #1;
      chk("t4_f0_ack", a_ack, 1);
      chk("t4_f0_addr", a_addr, 32'h400);
      @(negedge clk); a_redir_v = 1'b0; #1;
      chk("t4_f1_ov", a_ov, 0);
      chk("t4_f1_addr", a_addr, 32'h2000);
      @(negedge clk); #1;
      chk("t4_f2_ov", a_ov, 1);
      chk("t4_f2_pc", a_pc, 32'h2000);
      @(negedge clk); a_ready = 1'b1; a_redir_v = 1'b1; a_redir_pc = 32'h3007; #1;
      chk("t4_f3_ov", a_ov, 1);
      chk("t4_f3_pc", a_pc, 32'h2000);
      @(negedge clk); a_ready = 1'b0; a_redir_v = 1'b0; #1;
      chk("t4_f4_ov", a_ov, 0);
      chk("t4_f4_addr", a_addr, 32'h3004);
      @(negedge clk); #1;
      chk("t4_f5_pc", a_pc, 32'h3004);
      chk("t4_f5_pc4", a_pc4, 32'h3008);

      // Test 6: instruction 0x8C220004 fetched from 0x4C220004 into an empty FIFO
      @(negedge clk); a_rst = 1'b1; a_ready = 1'b0; #1;
      @(negedge clk); a_rst = 1'b0; a_redir_v = 1'b1; a_redir_pc = 32'h4C22_0004; #1;
      @(negedge clk); a_redir_v = 1'b0; a_ready = 1'b1; #1;
      chk("t6_h1_addr", a_addr, 32'h4C22_0004);
      chk("t6_h1_rdata", a_rdata, 32'h8C22_0004);
`ifdef MIPS_FETCH_BYPASS_EN
      chk("t6_h1_ov", a_ov, 1);
      chk("t6_h1_instr", a_instr, 32'h8C22_0004);
      chk("t6_h1_pc", a_pc, 32'h4C22_0004);
      @(negedge clk); a_ready = 1'b0; #1;
      chk("t6_h2_ov_not_pushed", a_ov, 0);
`else
      chk("t6_h1_ov", a_ov, 0);
      @(negedge clk); a_ready = 1'b0; #1;
      chk("t6_h2_ov", a_ov, 1);
      chk("t6_h2_instr", a_instr, 32'h8C22_0004);
      chk("t6_h2_pc4", a_pc4, 32'h4C22_0008);
`endif

      // Test 5: PC wrap from RESET_PC 0xFFFFFFF8
      @(negedge clk); b_rst = 1'b0; #1;
      chk("t5_g0_req", b_req, 1);
      chk("t5_g0_addr", b_addr, 32'hFFFF_FFF8);
      chk("t5_g0_ov", b_ov, 0);
      @(negedge clk); #1;
      chk("t5_g1_addr", b_addr, 32'hFFFF_FFFC);
      chk("t5_g1_pc", b_pc, 32'hFFFF_FFF8);
      chk("t5_g1_pc4", b_pc4, 32'hFFFF_FFFC);
      @(negedge clk); b_ready = 1'b1; #1;
      chk("t5_g2_addr", b_addr, 32'h0000_0000);
      @(negedge clk); b_ready = 1'b0; #1;
      chk("t5_g3_pc", b_pc, 32'hFFFF_FFFC);
      chk("t5_g3_pc4", b_pc4, 32'h0000_0000);
      chk("t5_g3_instr", b_instr, 32'h3FFF_FFFC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Parametrised instruction-fetch front end for the MIPS core. It replaces the single-cycle PC register and PC+4 adder path with a fetch engine that supports:
- a variable-latency instruction memory using a req/ack handshake;
- a prefetch FIFO of configurable depth;
- branch/jump redirect with flush.

It sits between the instruction memory and decode. It delivers {instr, pc, pc+4} to decode over a valid/ready interface.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- DATA_WIDTH, 32, instruction width.
- FIFO_DEPTH, 4, prefetch entries (power of two, >=2).
- RESET_PC, 0, PC loaded on reset (low 2 bits must be 0).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_WIDTH  fetch address, stable while imem_req=1.
- imem_ack  in  1  request completed; imem_rdata valid this cycle.
- imem_rdata  in  DATA_WIDTH  fetched instruction.
- redirect_valid  in  1  branch/jump taken, one-cycle pulse.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  DATA_WIDTH  head instruction.
- out_pc  out  ADDR_WIDTH  head PC.
- out_pc_plus4  out  ADDR_WIDTH  head PC+4, modulo 2^ADDR_WIDTH.

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc=RESET_PC, FIFO empty, state=FETCH.
  - Outputs during/after reset: out_valid=0, imem_req=0 in the reset cycle; out_instr/out_pc/out_pc_plus4=0.
  - Reset mid-request abandons the transaction. The memory must also be reset.
- Memory handshake:
  - imem_req held high with a constant imem_addr until imem_ack.
  - Ack may come in the same cycle as req (zero wait) or any later cycle.
  - At most one outstanding request.
- State machine:
  - FETCH: imem_req=1, imem_addr=fetch_pc.
    - On ack with no redirect: push {rdata, fetch_pc}; fetch_pc+=4.
    - If the FIFO would then hold FIFO_DEPTH entries after that cycle's pop, next state is STALL; else stay in FETCH.
  - STALL: imem_req=0. Go to FETCH the cycle after a pop occurs.
  - DISCARD: imem_req=1 with the old address until ack. The response is dropped. fetch_pc already holds the redirect target. Then go to FETCH.
- Redirect (highest priority):
  - FIFO flushed (out_valid=0 next cycle).
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - In FETCH without ack, the request cannot be withdrawn: go to DISCARD.
  - In FETCH with ack in the same cycle: the response is dropped; next state FETCH.
  - In STALL: next state FETCH.
  - In DISCARD: update the target only; stay in DISCARD.
  - A pop in the redirect cycle is still honoured by decode (the head is consumed); flush takes effect after.
- Latency: without bypass, an instruction acked in cycle N is visible on out_* in cycle N+1.
- FIFO:
  - Simultaneous push and pop when full is not possible (STALL blocks requests).
  - Push and pop when partially full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- PC arithmetic is unsigned, modulo 2^ADDR_WIDTH: 0xFFFFFFFC+4 = 0x00000000.

Optional Feature:
MIPS_FETCH_BYPASS_EN:
- Defined: when the FIFO is empty, ack arrives, no redirect, and out_ready=1, the data goes straight to out_* in the same cycle (out_valid=1) and is not pushed. Zero-cycle fetch-to-decode latency.
- Undefined: every instruction passes through the FIFO; latency is 1 cycle minimum.

Decomposition:
- Package mips_pkg:
  - ADDR_WIDTH/DATA_WIDTH defaults;
  - INSTR_ALIGN_MASK;
  - fetch_state_t enum {FETCH, STALL, DISCARD};
  - fetch_entry_t struct {instr, pc}.
- Sub-module mips_fetch_fifo: synchronous FIFO of fetch_entry_t with push/pop/flush/count, parametrised by FIFO_DEPTH.

Test Plan:
1. Reset with RESET_PC=0x400, zero-wait memory, out_ready=1 -> imem_addr sequence 0x400, 0x404, 0x408; out_pc matches one cycle later; out_pc_plus4=0x404 for the first entry.
2. Hold out_ready=0, FIFO_DEPTH=4 -> exactly 4 acks accepted, then imem_req=0. Assert out_ready for one cycle -> imem_req rises the next cycle with addr 0x410.
3. Memory 3-cycle latency; redirect_valid with redirect_pc=0x1002 in wait cycle 1 -> imem_addr stays 0x400 until ack; that response is dropped; next request addr=0x1000; no out_valid for 0x400.
4. Redirect in the same cycle as ack -> acked data never appears; FIFO count=0 next cycle.
5. RESET_PC=0xFFFFFFF8, zero-wait memory -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; out_pc_plus4 for 0xFFFFFFFC = 0x00000000.
6. With MIPS_FETCH_BYPASS_EN, FIFO empty, ack with rdata=0x8C220004 and out_ready=1 -> out_valid=1 and out_instr=0x8C220004 in the same cycle; FIFO count stays 0.
